fetch_step_controller: RTL and testbench
========================================

Name: fetch_step_controller

Overview:
Sequences the instruction fetch unit for board-level debug: free-run at a divided rate, single-step from a push button, or halt on a PC breakpoint. Emits a one-cycle advance enable to the fetch unit's PC register. Captures the low halves of the instruction and PC into stable registers that feed the two 4-digit display driver. Sits between board switches/buttons, the fetch unit and the display driver, all on the fast board clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
RUN_DIV, 50000000, clock cycles per advance in RUN state (must be >= 2).
CNT_W, 26, width of the rate and debounce counters (must hold max(DEBOUNCE_CYCLES, RUN_DIV)).

Ports:
Clk  in  1  board clock; single clock domain.
Reset  in  1  synchronous, active-high reset.
RunSw  in  1  run switch, level, asynchronous to Clk.
StepBtn  in  1  step push button, raw, asynchronous, bouncy.
BreakEn  in  1  breakpoint enable, level.
BreakAddr  in  16  breakpoint PC, compared against PCResult[15:0].
PCResult  in  32  current PC from the fetch unit.
Instruction  in  32  current instruction from the fetch unit.
AdvanceEn  out  1  one-cycle pulse; the fetch unit updates PC on the edge where this is high.
DispInstr  out  16  captured Instruction[15:0] for the display.
DispPC  out  16  captured PCResult[15:0] for the display.
State  out  2  current state encoding (HALT=00, RUN=01, STEP=10, BREAK=11).

Behaviour:
- Reset: State=HALT, AdvanceEn=0, DispInstr=0, DispPC=0, rate counter=0, debouncer cleared (accepted level 0, counter 0), sync flops 0. Reset asserted mid-operation aborts everything on the next edge with these values.
- RunSw and StepBtn each pass through a 2-flop synchronizer. BreakEn and BreakAddr are quasi-static and are not synchronized.
- Debounce: the synchronized StepBtn must differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles before the accepted level flips. Any return to the accepted level restarts the count.
- A 0->1 flip of the accepted level produces a one-cycle step pulse. Release produces no pulse.
- HALT:
  - Synchronized RunSw=1 -> RUN, with the rate counter starting at 0.
  - Otherwise, a step pulse -> STEP.
  - When RunSw=1 and a step pulse occur together, RUN wins and the step pulse is dropped.
- STEP: AdvanceEn=1 for exactly this one cycle, then unconditionally -> HALT.
- RUN:
  - The rate counter counts 0..RUN_DIV-1 and wraps to 0.
  - At terminal count, if BreakEn=1 and PCResult[15:0]==BreakAddr: no advance, -> BREAK.
  - At terminal count otherwise: AdvanceEn=1 for that one cycle.
  - RunSw=0 -> HALT in the same cycle, even at terminal count: no advance, counter cleared.
  - Step pulses are ignored.
- BREAK:
  - AdvanceEn=0.
  - RunSw=0 -> HALT.
  - A step pulse -> STEP, which steps past the breakpoint. From the following HALT, RunSw still high resumes RUN.
- The rate counter is held at 0 in every state except RUN.
- AdvanceEn is a registered output. It is high only in STEP, or in RUN at terminal count without a breakpoint hit. It is never high on two consecutive cycles.
- Display capture: DispInstr/DispPC load Instruction[15:0]/PCResult[15:0] two cycles after each AdvanceEn pulse (AdvanceEn delayed 2 flops). They also load on the first cycle after Reset deasserts. They are held at all other times, so the display never shows mid-update values.
- Breakpoint compare uses the live PCResult. A breakpoint at the reset PC with BreakEn=1 halts before the first advance.

Decomposition:
- Shared package fetch_ctrl_pkg:
  - state encoding constants: HALT, RUN, STEP, BREAK.
  - default DEBOUNCE_CYCLES and RUN_DIV.
- One sub-module: button_debouncer.
  - Contains the 2-flop sync, the stability counter, the accepted level and the rising-edge pulse.
  - Parameterized by DEBOUNCE_CYCLES.
  - Reused for future board buttons.
- The FSM, rate counter and display capture stay in fetch_step_controller.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=8):
- Reset held 3 cycles, then released -> State=00, AdvanceEn=0; DispPC/DispInstr load the fetch-unit values on the first cycle after release.
- StepBtn high for 3 cycles then low, then high for 10 cycles -> the 3-cycle glitch produces no pulse. The 10-cycle press produces exactly one AdvanceEn pulse, State goes 00->10->00, and DispPC updates 2 cycles after the pulse (e.g. 0x0000 -> 0x0004).
- RunSw=1 for 40 cycles -> AdvanceEn pulses every 8 cycles (5 pulses). Each is a single cycle, and the first comes 8 cycles after RUN entry.
- BreakEn=1, BreakAddr=0x000C, RunSw=1 from PC=0 -> advances to 0x000C, then State=11 with no further AdvanceEn. A step pulse gives one advance to 0x0010, then State 10->00->01.
- RunSw=1 and a step pulse in the same cycle in HALT -> State=01, no STEP, no immediate AdvanceEn.
- Reset asserted in RUN with the rate counter at 5 -> next edge State=00, AdvanceEn=0, counter=0. No advance occurs at the old terminal count.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared state encoding and board-rate defaults for the fetch step controller.
// Defaults assume a 100 MHz board clock.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_RUN_DIV         = 50000000;
  localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw push button; emits a one-cycle pulse on an accepted press.
// Pulse appears 2 sync cycles + DEBOUNCE_CYCLES after the raw level settles high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input matches the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/fetch_step_controller.sv
// Debug sequencer for the fetch unit: divided free-run, single-step, PC breakpoint halt.
// AdvanceEn is registered; display registers reload 2 cycles after each advance pulse.
module fetch_step_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RunSw,
  input  logic        StepBtn,
  input  logic        BreakEn,
  input  logic [15:0] BreakAddr,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  output logic        AdvanceEn,
  output logic [15:0] DispInstr,
  output logic [15:0] DispPC,
  output logic [1:0]  State
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(RUN_DIV - 1);

  state_e           state_q;
  logic             adv_q;
  logic [CNT_W-1:0] rate_q;
  logic             run_sync1_q, run_sync2_q;
  logic             step_pulse;
  logic             bp_hit;
  logic             adv_dly1_q, adv_dly2_q;
  logic             load_first_q;
  logic [15:0]      disp_instr_q, disp_pc_q;
  logic             unused_hi;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_btn (
    .clk_i (Clk),
    .rst_i (Reset),
    .btn_i (StepBtn),
    .rise_o(step_pulse)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_sync1_q <= 1'b0;
      run_sync2_q <= 1'b0;
    end else begin
      run_sync1_q <= RunSw;
      run_sync2_q <= run_sync1_q;
    end
  end

  assign bp_hit = BreakEn && (PCResult[15:0] == BreakAddr);

  // Rate counter rests at 0 outside RUN, so every RUN entry starts a full period.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= HALT;
      adv_q   <= 1'b0;
      rate_q  <= '0;
    end else begin
      adv_q  <= 1'b0;
      rate_q <= '0;
      case (state_q)
        HALT: begin
          if (run_sync2_q) begin
            state_q <= RUN;
          end else if (step_pulse) begin
            state_q <= STEP;
            adv_q   <= 1'b1;
          end
        end
        STEP: begin
          state_q <= HALT;
        end
        RUN: begin
          if (!run_sync2_q) begin
            state_q <= HALT;
          end else if (rate_q == TERM) begin
            if (bp_hit) begin
              state_q <= BREAK;
            end else begin
              adv_q <= 1'b1;
            end
          end else begin
            rate_q <= rate_q + 1'b1;
          end
        end
        BREAK: begin
          if (!run_sync2_q) begin
            state_q <= HALT;
          end else if (step_pulse) begin
            state_q <= STEP;
            adv_q   <= 1'b1;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  // Capture waits for the fetch unit to settle on the new PC and instruction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      adv_dly1_q   <= 1'b0;
      adv_dly2_q   <= 1'b0;
      load_first_q <= 1'b1;
      disp_instr_q <= '0;
      disp_pc_q    <= '0;
    end else begin
      adv_dly1_q   <= adv_q;
      adv_dly2_q   <= adv_dly1_q;
      load_first_q <= 1'b0;
      if (adv_dly2_q || load_first_q) begin
        disp_instr_q <= Instruction[15:0];
        disp_pc_q    <= PCResult[15:0];
      end
    end
  end

  assign unused_hi = ^{PCResult[31:16], Instruction[31:16]};

  assign AdvanceEn = adv_q;
  assign DispInstr = disp_instr_q;
  assign DispPC    = disp_pc_q;
  assign State     = state_q;

endmodule

// File: tb/tb_fetch_step_controller.sv
// Directed bench for fetch_step_controller with a small PC-increment fetch model.
module tb_fetch_step_controller;
  import fetch_ctrl_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        RunSw;
  logic        StepBtn;
  logic        BreakEn;
  logic [15:0] BreakAddr;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        AdvanceEn;
  logic [15:0] DispInstr;
  logic [15:0] DispPC;
  logic [1:0]  State;

  int checks = 0;
  int failures = 0;
  int adv_cnt = 0;
  int consec_cnt = 0;
  logic prev_adv = 1'b0;

  fetch_step_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (8),
    .CNT_W          (26)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .RunSw      (RunSw),
    .StepBtn    (StepBtn),
    .BreakEn    (BreakEn),
    .BreakAddr  (BreakAddr),
    .PCResult   (PCResult),
    .Instruction(Instruction),
    .AdvanceEn  (AdvanceEn),
    .DispInstr  (DispInstr),
    .DispPC     (DispPC),
    .State      (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Fetch unit model: PC steps by 4 on each advance edge.
  always @(posedge Clk) begin
    if (Reset) PCResult <= 32'h0;
    else if (AdvanceEn) PCResult <= PCResult + 32'd4;
  end
  assign Instruction = {16'hC0DE, PCResult[15:0] ^ 16'h5A5A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick();
    @(posedge Clk);
    #1;
    if (AdvanceEn === 1'b1) begin
      adv_cnt++;
      if (prev_adv) consec_cnt++;
    end
    prev_adv = (AdvanceEn === 1'b1);
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task wait_state(input logic [1:0] s, input int bound, output int n);
    n = 0;
    while (State !== s && n < bound) begin
      tick();
      n++;
    end
  endtask

  task wait_adv(input int bound, output int found);
    int n;
    n = 0;
    found = 0;
    while (found == 0 && n < bound) begin
      tick();
      n++;
      if (AdvanceEn === 1'b1) found = 1;
    end
  endtask

  initial begin
    int a0, n, found, first, last, saw_step;

    Reset = 1'b1; RunSw = 1'b0; StepBtn = 1'b0; BreakEn = 1'b0; BreakAddr = 16'h0;
    ticks(3);
    chk("rst_state", State, HALT);
    chk("rst_adv", AdvanceEn, 0);
    chk("rst_disp_pc", DispPC, 0);
    chk("rst_disp_instr", DispInstr, 0);
    Reset = 1'b0;
    tick();
    chk("first_load_instr", DispInstr, 16'h5A5A);
    chk("first_load_pc", DispPC, 16'h0000);
    ticks(5);

    // 3-cycle glitch must not be accepted
    a0 = adv_cnt;
    StepBtn = 1'b1; ticks(3); StepBtn = 1'b0; ticks(15);
    chk("glitch_no_adv", adv_cnt - a0, 0);
    chk("glitch_state", State, HALT);

    // 10-cycle press: one step
    StepBtn = 1'b1;
    wait_adv(20, found);
    chk("step_found", found, 1);
    chk("step_state", State, STEP);
    tick();
    chk("step_back_halt", State, HALT);
    chk("step_single_cycle", AdvanceEn, 0);
    tick();
    chk("step_disp_hold", DispPC, 16'h0000);
    tick();
    chk("step_disp_pc", DispPC, 16'h0004);
    chk("step_disp_instr", DispInstr, 16'h5A5E);
    StepBtn = 1'b0;
    a0 = adv_cnt;
    ticks(15);
    chk("release_no_adv", adv_cnt - a0, 0);

    // Free run: 40 cycles -> 5 pulses, first 8 cycles after entry
    RunSw = 1'b1;
    wait_state(RUN, 10, n);
    chk("run_entry", State, RUN);
    chk("run_entry_delay", n, 3);
    first = 0; last = 0; a0 = adv_cnt;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (AdvanceEn === 1'b1) begin
        if (first == 0) first = i;
        last = i;
      end
    end
    chk("run_first_adv", first, 8);
    chk("run_last_adv", last, 40);
    chk("run_pulses", adv_cnt - a0, 5);
    RunSw = 1'b0;
    a0 = adv_cnt;
    ticks(5);
    chk("run_stop_state", State, HALT);
    chk("run_pc", PCResult, 32'h18);
    ticks(3);
    chk("run_disp_pc", DispPC, 16'h0018);
    chk("run_stop_no_adv", adv_cnt - a0, 0);

    // Breakpoint at 0x000C from PC=0
    Reset = 1'b1; ticks(2); Reset = 1'b0; tick();
    BreakEn = 1'b1; BreakAddr = 16'h000C; RunSw = 1'b1;
    a0 = adv_cnt;
    wait_state(BREAK, 100, n);
    chk("bp_state", State, BREAK);
    chk("bp_pulses", adv_cnt - a0, 3);
    chk("bp_pc", PCResult, 32'hC);
    a0 = adv_cnt;
    ticks(20);
    chk("bp_hold_no_adv", adv_cnt - a0, 0);
    chk("bp_hold_state", State, BREAK);
    StepBtn = 1'b1;
    wait_adv(20, found);
    chk("bp_step_found", found, 1);
    chk("bp_step_state", State, STEP);
    tick();
    chk("bp_step_halt", State, HALT);
    chk("bp_step_pc", PCResult, 32'h10);
    tick();
    chk("bp_resume_run", State, RUN);
    RunSw = 1'b0; StepBtn = 1'b0; BreakEn = 1'b0;
    ticks(15);
    chk("bp_exit_halt", State, HALT);

    // RunSw and step pulse land in the same HALT cycle
    StepBtn = 1'b1; ticks(4);
    RunSw = 1'b1; ticks(2);
    chk("sim_pre_state", State, HALT);
    tick();
    chk("sim_state_run", State, RUN);
    chk("sim_no_adv", AdvanceEn, 0);
    first = 0; saw_step = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (State === STEP) saw_step = 1;
      if (AdvanceEn === 1'b1 && first == 0) first = i;
    end
    chk("sim_no_step", saw_step, 0);
    chk("sim_first_adv", first, 8);

    // Reset mid-RUN with rate counter at 5
    ticks(5);
    Reset = 1'b1; StepBtn = 1'b0;
    tick();
    chk("midrst_state", State, HALT);
    chk("midrst_adv", AdvanceEn, 0);
    Reset = 1'b0;
    a0 = adv_cnt;
    wait_state(RUN, 10, n);
    chk("midrst_no_old_adv", adv_cnt - a0, 0);
    chk("midrst_reentry", n, 3);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (AdvanceEn === 1'b1 && first == 0) first = i;
    end
    chk("midrst_first_adv", first, 8);

    // Breakpoint at the reset PC halts before any advance
    RunSw = 1'b0; Reset = 1'b1; BreakEn = 1'b1; BreakAddr = 16'h0000;
    ticks(2);
    Reset = 1'b0; RunSw = 1'b1;
    a0 = adv_cnt;
    wait_state(BREAK, 40, n);
    chk("bp0_state", State, BREAK);
    chk("bp0_no_adv", adv_cnt - a0, 0);
    chk("bp0_pc", PCResult, 32'h0);
    RunSw = 1'b0;
    ticks(5);
    chk("bp0_exit_halt", State, HALT);

    chk("never_consecutive_adv", consec_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
